// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types for the register-file write arbiter: default widths, write modes, request struct.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_write_arbiter_pkg;

    localparam int WIDTH        = 32;
    localparam int REG_ADDR_LEN = 5;

    localparam logic [1:0] WMODE_WORD = 2'd0;
    localparam logic [1:0] WMODE_HALF = 2'd1;
    localparam logic [1:0] WMODE_BYTE = 2'd2;

    // Write request at the default widths.
    typedef struct packed {
        logic [REG_ADDR_LEN-1:0] addr;
        logic [WIDTH-1:0]        data;
        logic [1:0]              w_mode;
    } wr_req_t;

    // Which requester owns the write port this cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WB   = 2'd1,
        GNT_LU   = 2'd2
    } gnt_e;

endpackage

// File: rtl/regfile_write_arbiter_wb_req_fifo.sv
// Synchronous DEPTH-entry FIFO holding long-latency write requests.
// Latency: a pushed entry is visible at dout the cycle after the push (no bypass).
// Backpressure: push ignored when full, pop ignored when empty; same-cycle push+pop allowed when not full.
// Ports: clk, rst (sync, active-high), push/din, pop/dout, full, empty.
module wb_req_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    // One extra pointer bit separates the full and empty cases when the indices match.
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset; only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (!rst && push && !full) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between WriteBack (fixed priority) and a FIFO-buffered long-latency unit.
// Latency: granted request appears on rf_* one cycle later; LU entries are grantable one cycle after push.
// Backpressure: WB has none; LU uses lu_ready = !full; stall_req pulses to force the FIFO head out.
// Ports: clk/rst (sync, active-high); wb_* WriteBack request; lu_* long-latency request with lu_ready;
//        rf_* register-file write port; stall_req bubble request; proto_err sticky WB-during-stall flag.
// Optional: define ARB_STATS_EN to add 16-bit saturating grant counters stat_wb_grants/stat_lu_grants/stat_forced.
module regfile_write_arbiter #(
    parameter int WIDTH        = regfile_write_arbiter_pkg::WIDTH,
    parameter int REG_ADDR_LEN = regfile_write_arbiter_pkg::REG_ADDR_LEN,
    parameter int DEPTH        = 4,
    parameter int MAX_WAIT     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wb_wr_en,
    input  logic [REG_ADDR_LEN-1:0] wb_addr,
    input  logic [WIDTH-1:0]        wb_data,
    input  logic [1:0]              wb_w_mode,
    input  logic                    lu_valid,
    output logic                    lu_ready,
    input  logic [REG_ADDR_LEN-1:0] lu_addr,
    input  logic [WIDTH-1:0]        lu_data,
    input  logic [1:0]              lu_w_mode,
    output logic                    stall_req,
    output logic                    rf_wr_en,
    output logic [REG_ADDR_LEN-1:0] rf_addr,
    output logic [WIDTH-1:0]        rf_data,
    output logic [1:0]              rf_w_mode,
    output logic                    proto_err
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]             stat_wb_grants,
    output logic [15:0]             stat_lu_grants,
    output logic [15:0]             stat_forced
`endif
);

    import regfile_write_arbiter_pkg::*;

    localparam int CW = $clog2(MAX_WAIT);
    localparam logic [CW-1:0] STARVE_MAX = CW'(MAX_WAIT - 1);

    typedef struct packed {
        logic [REG_ADDR_LEN-1:0] addr;
        logic [WIDTH-1:0]        data;
        logic [1:0]              w_mode;
    } req_t;

    req_t          lu_req;
    req_t          head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          head_gnt;
    gnt_e          gnt;
    logic [CW-1:0] starve_cnt;

    assign lu_req   = '{addr: lu_addr, data: lu_data, w_mode: lu_w_mode};
    assign lu_ready = !fifo_full;
    // No pop credit: a full FIFO refuses a push even when the head leaves this cycle.
    assign push     = lu_valid && !fifo_full;

    wb_req_fifo #(
        .W     ($bits(req_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (lu_req),
        .pop   (head_gnt),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // stall_req outranks WB so the pipeline bubble is actually spent on the starved head.
    always_comb begin
        gnt = GNT_NONE;
        if (stall_req && !fifo_empty) begin
            gnt = GNT_LU;
        end else if (wb_wr_en) begin
            gnt = GNT_WB;
        end else if (!fifo_empty) begin
            gnt = GNT_LU;
        end
    end

    assign head_gnt = (gnt == GNT_LU);

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wr_en   <= 1'b0;
            rf_addr    <= '0;
            rf_data    <= '0;
            rf_w_mode  <= WMODE_WORD;
            starve_cnt <= '0;
            stall_req  <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            rf_wr_en <= (gnt != GNT_NONE);
            if (gnt == GNT_WB) begin
                rf_addr   <= wb_addr;
                rf_data   <= wb_data;
                rf_w_mode <= wb_w_mode;
            end else if (gnt == GNT_LU) begin
                rf_addr   <= head.addr;
                rf_data   <= head.data;
                rf_w_mode <= head.w_mode;
            end

            if (fifo_empty || head_gnt) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STARVE_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end

            // Single-cycle pulse: the next cycle's forced grant clears the condition.
            stall_req <= !fifo_empty && !head_gnt && (starve_cnt == STARVE_MAX);
            proto_err <= proto_err || (wb_wr_en && stall_req);
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_wb_grants <= '0;
            stat_lu_grants <= '0;
            stat_forced    <= '0;
        end else begin
            if (gnt == GNT_WB && stat_wb_grants != 16'hFFFF) begin
                stat_wb_grants <= stat_wb_grants + 16'd1;
            end
            if (gnt == GNT_LU && stat_lu_grants != 16'hFFFF) begin
                stat_lu_grants <= stat_lu_grants + 16'd1;
            end
            if (stall_req && stat_forced != 16'hFFFF) begin
                stat_forced <= stat_forced + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios then randomized traffic vs a queue model.
// Latency: model predicts rf_* one cycle after each driven cycle.
// Backpressure: model tracks FIFO occupancy to predict lu_ready and the starvation stall.
module tb_regfile_write_arbiter;

    import regfile_write_arbiter_pkg::*;

    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_wr_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic [1:0]  wb_w_mode = '0;
    logic        lu_valid = 1'b0;
    logic        lu_ready;
    logic [4:0]  lu_addr = '0;
    logic [31:0] lu_data = '0;
    logic [1:0]  lu_w_mode = '0;
    logic        stall_req;
    logic        rf_wr_en;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic [1:0]  rf_w_mode;
    logic        proto_err;

    regfile_write_arbiter #(
        .WIDTH        (32),
        .REG_ADDR_LEN (5),
        .DEPTH        (DEPTH),
        .MAX_WAIT     (MAX_WAIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_wr_en  (wb_wr_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .wb_w_mode (wb_w_mode),
        .lu_valid  (lu_valid),
        .lu_ready  (lu_ready),
        .lu_addr   (lu_addr),
        .lu_data   (lu_data),
        .lu_w_mode (lu_w_mode),
        .stall_req (stall_req),
        .rf_wr_en  (rf_wr_en),
        .rf_addr   (rf_addr),
        .rf_data   (rf_data),
        .rf_w_mode (rf_w_mode),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: pending LU writes as a queue, plus how long the oldest has been passed over.
    wr_req_t     mq[$];
    int          m_passed = 0;
    bit          m_stall  = 1'b0;
    bit          m_perr   = 1'b0;
    bit          e_wr_en  = 1'b0;
    logic [4:0]  e_addr   = '0;
    logic [31:0] e_data   = '0;
    logic [1:0]  e_mode   = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs (called at negedge), advance the model, then check at the next negedge.
    task automatic step(input bit r, input bit we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [1:0] wm, input bit lv, input logic [4:0] la,
                        input logic [31:0] ld, input logic [1:0] lm);
        bit      pending;
        bit      lu_wins;
        bit      can_push;
        wr_req_t nreq;
        rst = r; wb_wr_en = we; wb_addr = wa; wb_data = wd; wb_w_mode = wm;
        lu_valid = lv; lu_addr = la; lu_data = ld; lu_w_mode = lm;

        if (r) begin
            mq.delete();
            m_passed = 0; m_stall = 1'b0; m_perr = 1'b0;
            e_wr_en = 1'b0; e_addr = '0; e_data = '0; e_mode = '0;
        end else begin
            pending  = (mq.size() > 0);
            can_push = lv && (mq.size() < DEPTH);
            lu_wins  = pending && (m_stall || !we);
            m_perr   = m_perr || (we && m_stall);
            e_wr_en  = lu_wins || we;
            if (lu_wins) begin
                e_addr = mq[0].addr; e_data = mq[0].data; e_mode = mq[0].w_mode;
                void'(mq.pop_front());
            end else if (we) begin
                e_addr = wa; e_data = wd; e_mode = wm;
            end
            m_stall = pending && !lu_wins && (m_passed == MAX_WAIT - 1);
            if (!pending || lu_wins) m_passed = 0;
            else if (m_passed < MAX_WAIT - 1) m_passed = m_passed + 1;
            if (can_push) begin
                nreq.addr = la; nreq.data = ld; nreq.w_mode = lm;
                mq.push_back(nreq);
            end
        end

        @(posedge clk);
        @(negedge clk);
        chk("rf_wr_en",  64'(rf_wr_en),  64'(e_wr_en));
        chk("rf_addr",   64'(rf_addr),   64'(e_addr));
        chk("rf_data",   64'(rf_data),   64'(e_data));
        chk("rf_w_mode", 64'(rf_w_mode), 64'(e_mode));
        chk("stall_req", 64'(stall_req), 64'(m_stall));
        chk("lu_ready",  64'(lu_ready),  64'(mq.size() < DEPTH));
        chk("proto_err", 64'(proto_err), 64'(m_perr));
    endtask

    task automatic idle();
        step(0, 0, 5'd0, 32'd0, 2'd0, 0, 5'd0, 32'd0, 2'd0);
    endtask

    initial begin
        int k;
        int pct;
        @(negedge clk);
        step(1, 0, 5'd0, 32'd0, 2'd0, 0, 5'd0, 32'd0, 2'd0);
        step(1, 0, 5'd0, 32'd0, 2'd0, 0, 5'd0, 32'd0, 2'd0);
        chk("rst_rf_wr_en", 64'(rf_wr_en), 64'd0);
        chk("rst_lu_ready", 64'(lu_ready), 64'd1);
        chk("rst_stall",    64'(stall_req), 64'd0);
        chk("rst_perr",     64'(proto_err), 64'd0);

        // WB only
        step(0, 1, 5'd3, 32'hDEADBEEF, WMODE_WORD, 0, 5'd0, 32'd0, 2'd0);
        chk("wb_only_en",   64'(rf_wr_en), 64'd1);
        chk("wb_only_addr", 64'(rf_addr),  64'd3);
        chk("wb_only_data", 64'(rf_data),  64'hDEADBEEF);
        chk("wb_only_rdy",  64'(lu_ready), 64'd1);

        // LU only: no bypass, write two cycles after push
        step(0, 0, 5'd0, 32'd0, 2'd0, 1, 5'd7, 32'h1234, WMODE_HALF);
        chk("lu_only_n1_en", 64'(rf_wr_en), 64'd0);
        idle();
        chk("lu_only_en",   64'(rf_wr_en),  64'd1);
        chk("lu_only_addr", 64'(rf_addr),   64'd7);
        chk("lu_only_data", 64'(rf_data),   64'h1234);
        chk("lu_only_mode", 64'(rf_w_mode), 64'(WMODE_HALF));
        idle();
        chk("lu_only_drained", 64'(rf_wr_en), 64'd0);

        // Simultaneous requests: WB first, LU next cycle
        step(0, 1, 5'd2, 32'h2222, WMODE_WORD, 1, 5'd9, 32'h9999, WMODE_BYTE);
        chk("simul_wb_addr", 64'(rf_addr), 64'd2);
        idle();
        chk("simul_lu_en",   64'(rf_wr_en), 64'd1);
        chk("simul_lu_addr", 64'(rf_addr),  64'd9);
        idle();

        // Starvation: continuous WB, pulled back only during the stall cycle
        step(0, 1, 5'd1, 32'h11, WMODE_WORD, 1, 5'd12, 32'hCAFE0001, WMODE_BYTE);
        k = 0;
        while (!stall_req && k < 20) begin
            step(0, 1, 5'($urandom), $urandom, WMODE_WORD, 0, 5'd0, 32'd0, 2'd0);
            k++;
        end
        chk("starve_cycles", 64'(k), 64'd8);
        step(0, 0, 5'd0, 32'd0, 2'd0, 0, 5'd0, 32'd0, 2'd0);
        chk("starve_lu_en",   64'(rf_wr_en),  64'd1);
        chk("starve_lu_addr", 64'(rf_addr),   64'd12);
        chk("starve_lu_data", 64'(rf_data),   64'hCAFE0001);
        chk("starve_perr",    64'(proto_err), 64'd0);
        chk("starve_pulse",   64'(stall_req), 64'd0);

        // Fill the FIFO under WB pressure, then violate the stall
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 5'd1, 32'h1, WMODE_WORD, 1, 5'(20 + i), 32'h2000_0000 + 32'(20 + i), WMODE_WORD);
        end
        chk("full_rdy", 64'(lu_ready), 64'd0);
        k = 0;
        while (!stall_req && k < 20) begin
            step(0, 1, 5'd1, 32'h1, WMODE_WORD, 1, 5'd30, 32'h30, WMODE_WORD);
            k++;
        end
        step(0, 1, 5'd31, 32'hBAD0BAD0, WMODE_WORD, 0, 5'd0, 32'd0, 2'd0);
        chk("viol_perr", 64'(proto_err), 64'd1);
        chk("viol_addr", 64'(rf_addr),   64'd20);
        chk("viol_data", 64'(rf_data),   64'h2000_0014);
        for (int i = 0; i < 6; i++) idle();

        // Reset with three entries queued
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 5'd4, 32'h4, WMODE_WORD, 1, 5'(10 + i), 32'(i), WMODE_WORD);
        end
        step(1, 0, 5'd0, 32'd0, 2'd0, 0, 5'd0, 32'd0, 2'd0);
        chk("mid_rst_rdy",   64'(lu_ready),  64'd1);
        chk("mid_rst_stall", 64'(stall_req), 64'd0);
        chk("mid_rst_en",    64'(rf_wr_en),  64'd0);
        chk("mid_rst_perr",  64'(proto_err), 64'd0);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("post_rst_en", 64'(rf_wr_en), 64'd0);
        end

        // Randomized traffic against the model, varying WB load to provoke starvation
        pct = 50;
        for (int c = 0; c < 4000; c++) begin
            bit r;
            bit we;
            bit lv;
            if (c % 500 == 0) pct = $urandom_range(30, 100);
            r  = ($urandom_range(0, 299) == 0);
            we = ($urandom_range(0, 99) < pct);
            if (m_stall && $urandom_range(0, 9) != 0) we = 1'b0;
            lv = ($urandom_range(0, 99) < 45);
            step(r, we, 5'($urandom), $urandom, 2'($urandom_range(0, 2)),
                 lv, 5'($urandom), $urandom, 2'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
